// File: rtl/morse_rx_pkg.sv
// Shared constants and types for the Morse receiver: ASCII codes, FSM states,
// symbol-code widths and the queued character record.
package morse_rx_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  // len counts up to MAX_SYM (<=7); only the last five symbols matter to decode
  localparam int LEN_W  = 3;
  localparam int CODE_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK  = 2'd1,
    S_SPACE = 2'd2,
    S_WGAP  = 2'd3
  } state_e;

  typedef struct packed {
    logic       err;
    logic [7:0] ascii;
  } char_t;

endpackage

// File: rtl/morse_rx_lut.sv
// Combinational Morse decode: {len, code} (dot=0, dash=1, first symbol is the
// MSB of the len-bit field) to ASCII; anything not in the table gives '?'.
module morse_rx_lut
  import morse_rx_pkg::*;
(
  input  logic [LEN_W-1:0]  len_i,
  input  logic [CODE_W-1:0] code_i,
  output logic              err_o,
  output logic [7:0]        ascii_o
);

  always_comb begin
    ascii_o = ASCII_QMARK;
    case ({len_i, code_i})
      8'b001_00000: ascii_o = "E";
      8'b001_00001: ascii_o = "T";
      8'b010_00000: ascii_o = "I";
      8'b010_00001: ascii_o = "A";
      8'b010_00010: ascii_o = "N";
      8'b010_00011: ascii_o = "M";
      8'b011_00000: ascii_o = "S";
      8'b011_00001: ascii_o = "U";
      8'b011_00010: ascii_o = "R";
      8'b011_00011: ascii_o = "W";
      8'b011_00100: ascii_o = "D";
      8'b011_00101: ascii_o = "K";
      8'b011_00110: ascii_o = "G";
      8'b011_00111: ascii_o = "O";
      8'b100_00000: ascii_o = "H";
      8'b100_00001: ascii_o = "V";
      8'b100_00010: ascii_o = "F";
      8'b100_00100: ascii_o = "L";
      8'b100_00110: ascii_o = "P";
      8'b100_00111: ascii_o = "J";
      8'b100_01000: ascii_o = "B";
      8'b100_01001: ascii_o = "X";
      8'b100_01010: ascii_o = "C";
      8'b100_01011: ascii_o = "Y";
      8'b100_01100: ascii_o = "Z";
      8'b100_01101: ascii_o = "Q";
      8'b101_11111: ascii_o = "0";
      8'b101_01111: ascii_o = "1";
      8'b101_00111: ascii_o = "2";
      8'b101_00011: ascii_o = "3";
      8'b101_00001: ascii_o = "4";
      8'b101_00000: ascii_o = "5";
      8'b101_10000: ascii_o = "6";
      8'b101_11000: ascii_o = "7";
      8'b101_11100: ascii_o = "8";
      8'b101_11110: ascii_o = "9";
      default:      ascii_o = ASCII_QMARK;
    endcase
  end

  // '?' is never a valid Morse result here, so it doubles as the error flag
  assign err_o = (ascii_o == ASCII_QMARK);

endmodule

// File: rtl/morse_rx.sv
// Morse key receiver: sync + debounce, mark/space timing FSM, symbol assembly,
// letter decode and a small output FIFO with valid/ready and sticky overflow.
module morse_rx
  import morse_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 16,
  parameter int unsigned CNT_W       = 30,
  parameter int unsigned DOT_MAX     = 2**24,
  parameter int unsigned LETTER_GAP  = 2**25,
  parameter int unsigned WORD_GAP    = 2**27,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned MAX_SYM     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_in,
  output logic [7:0] letter,
  output logic       err,
  output logic       valid,
  input  logic       ready,
  output logic       overflow,
  output logic       key,
  output logic       busy
);

  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = PTR_W + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [DB_W-1:0]        db_q;
  logic                   key_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], key_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Accept a new level only after DEBOUNCE consecutive cycles of disagreement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q  <= '0;
      key_q <= 1'b0;
    end else if (sync_out == key_q) begin
      db_q <= '0;
    end else if (db_q == DB_W'(DEBOUNCE - 1)) begin
      db_q  <= '0;
      key_q <= sync_out;
    end else begin
      db_q <= db_q + DB_W'(1);
    end
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CODE_W-1:0] code_q, code_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              long_q, long_d;
  logic              emit;
  char_t             emit_char, lut_char;

  morse_rx_lut u_lut (
    .len_i   (len_q),
    .code_i  (code_q),
    .err_o   (lut_char.err),
    .ascii_o (lut_char.ascii)
  );

  // Saturate so a stuck key stays a dash instead of wrapping into a dot
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    code_d    = code_q;
    len_d     = len_q;
    long_d    = long_q;
    emit      = 1'b0;
    emit_char = '{err: 1'b0, ascii: ASCII_SPACE};
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (key_q) state_d = S_MARK;
      end
      S_MARK: begin
        if (!key_q) begin
          if (len_q == LEN_W'(MAX_SYM)) begin
            long_d = 1'b1;
          end else begin
            code_d = {code_q[CODE_W-2:0], (cnt_q > CNT_W'(DOT_MAX))};
            len_d  = len_q + LEN_W'(1);
          end
          state_d = S_SPACE;
          cnt_d   = '0;
        end
      end
      S_SPACE: begin
        if (cnt_q == CNT_W'(LETTER_GAP)) begin
          // The letter is emitted even if the key rises this same cycle
          emit      = 1'b1;
          emit_char = long_q ? '{err: 1'b1, ascii: ASCII_QMARK} : lut_char;
          code_d    = '0;
          len_d     = '0;
          long_d    = 1'b0;
          if (key_q) begin
            state_d = S_MARK;
            cnt_d   = '0;
          end else begin
            state_d = S_WGAP;
          end
        end else if (key_q) begin
          state_d = S_MARK;
          cnt_d   = '0;
        end
      end
      S_WGAP: begin
        if (key_q) begin
          state_d = S_MARK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(WORD_GAP)) begin
          emit    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      len_q   <= '0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      len_q   <= len_d;
      long_q  <= long_d;
    end
  end

  char_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [FC_W-1:0]  fcnt_q;
  logic             ovf_q;
  logic             full, pop, push_ok;
  char_t            head;

  assign full    = (fcnt_q == FC_W'(FIFO_DEPTH));
  assign valid   = (fcnt_q != '0);
  assign pop     = valid & ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push_ok = emit & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_q] <= emit_char;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + PTR_W'(1);
      if (pop)     rd_q <= rd_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fcnt_q <= fcnt_q + FC_W'(1);
        2'b01:   fcnt_q <= fcnt_q - FC_W'(1);
        default: fcnt_q <= fcnt_q;
      endcase
      if (emit && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign head     = mem_q[rd_q];
  assign letter   = valid ? head.ascii : 8'h00;
  assign err      = valid & head.err;
  assign overflow = ovf_q;
  assign key      = key_q;
  assign busy     = (state_q != S_IDLE);

endmodule
